jk_excitation_driver: RTL and testbench

JK_EXCITATION_DRIVER -- requirements
Module: jk_excitation_driver

---
 rtl/jk_excitation_driver.sv | 141 ++++++++++++++
 tb/tb_jk_excitation_driver.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/jk_excitation_driver.sv
// Drives a target 8-bit q pattern into an external JK flop, MSB first, using
// set/reset or toggle excitation, and checks the flop's q feedback one cycle later.
module jk_excitation_driver (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_mode,
   output logic       J,
   output logic       K,
   input  logic       q_fb,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t     state_r, state_nx;
   logic [7:0] pat_r, pat_nx;
   logic       mode_r, mode_nx;
   logic [2:0] cnt_r, cnt_nx;
   logic       model_r, model_nx;
   logic       exp_r, exp_nx;
   logic       chk_r, chk_nx;
   logic       j_r, j_nx;
   logic       k_r, k_nx;
   logic       done_r, done_nx;
   logic       err_r, err_nx;
   logic [2:0] idx_s;
   logic       tgt_s;

   assign in_ready = (state_r == IDLE);
   assign busy     = (state_r == SHIFT) || (state_r == CHECK);
   assign J        = j_r;
   assign K        = k_r;
   assign done     = done_r;
   assign err      = err_r;

   // State and datapath registers; reset abandons any partial frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         pat_r   <= 8'h00;
         mode_r  <= 1'b0;
         cnt_r   <= 3'd0;
         model_r <= 1'b0;
         exp_r   <= 1'b0;
         chk_r   <= 1'b0;
         j_r     <= 1'b0;
         k_r     <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nx;
         pat_r   <= pat_nx;
         mode_r  <= mode_nx;
         cnt_r   <= cnt_nx;
         model_r <= model_nx;
         exp_r   <= exp_nx;
         chk_r   <= chk_nx;
         j_r     <= j_nx;
         k_r     <= k_nx;
         done_r  <= done_nx;
         err_r   <= err_nx;
      end
   end

   // Next-state, excitation and feedback-check logic
   always_comb begin
      state_nx = state_r;
      pat_nx   = pat_r;
      mode_nx  = mode_r;
      cnt_nx   = cnt_r;
      model_nx = model_r;
      exp_nx   = model_r;
      chk_nx   = 1'b0;
      j_nx     = 1'b0;
      k_nx     = 1'b0;
      done_nx  = 1'b0;
      err_nx   = err_r;
      idx_s    = 3'd6 - cnt_r;
      tgt_s    = pat_r[idx_s];

      // q_fb now reflects the excitation presented in the previous cycle
      if (chk_r && (q_fb != exp_r)) begin
         err_nx = 1'b1;
      end else begin
         err_nx = err_r;
      end

      case (state_r)
         IDLE: begin
            if (in_valid) begin
               pat_nx   = in_data;
               mode_nx  = in_mode;
               cnt_nx   = 3'd0;
               err_nx   = 1'b0;
               model_nx = in_data[7];
               j_nx     = in_data[7];
               k_nx     = ~in_data[7];
               state_nx = SHIFT;
            end else begin
               state_nx = IDLE;
            end
         end
         SHIFT: begin
            chk_nx = 1'b1;
            if (cnt_r == 3'd7) begin
               state_nx = CHECK;
            end else begin
               cnt_nx   = cnt_r + 3'd1;
               model_nx = tgt_s;
               if (tgt_s == model_r) begin
                  j_nx = 1'b0;
                  k_nx = 1'b0;
               end else if (mode_r) begin
                  j_nx = 1'b1;
                  k_nx = 1'b1;
               end else begin
                  j_nx = tgt_s;
                  k_nx = ~tgt_s;
               end
            end
         end
         CHECK: begin
            state_nx = IDLE;
            done_nx  = 1'b1;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver with a behavioural JK flop on q_fb
// and a queue of expected J/K excitations per frame cycle.
module tb_jk_excitation_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       in_mode = 1'b0;
   logic       J, K;
   logic       q_fb;
   logic       busy, done, err;
   logic       q_m = 1'b0;
   logic       stuck = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   logic [1:0] exp_q[$];

   jk_excitation_driver dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode), .J(J), .K(K), .q_fb(q_fb),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // External JK flop
   always @(posedge clk) begin
      case ({J, K})
         2'b01:   q_m <= 1'b0;
         2'b10:   q_m <= 1'b1;
         2'b11:   q_m <= ~q_m;
         default: q_m <= q_m;
      endcase
   end

   assign q_fb = stuck ? 1'b0 : q_m;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Expected {J,K} in frame cycle k (1..9)
   function automatic logic [1:0] exp_jk(input logic [7:0] d, input logic m, input int k);
      logic b, p;
      if (k >= 9) return 2'b00;
      b = d[8 - k];
      if (k == 1) return {b, ~b};
      p = d[9 - k];
      if (b == p) return 2'b00;
      if (m) return 2'b11;
      return {b, ~b};
   endfunction

   // Entered at a negedge in IDLE/done cycle; returns at the negedge of cycle 10
   task automatic frame(input logic [7:0] d, input logic m, input logic exp_err,
                        input logic keep, input logic [7:0] alt, input logic alt_m);
      logic [1:0] e;
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      for (int k = 1; k <= 9; k++) exp_q.push_back(exp_jk(d, m, k));
      @(negedge clk);
      if (keep) begin
         in_data = alt;
         in_mode = alt_m;
      end else begin
         in_valid = 1'b0;
         in_data  = ~d;
         in_mode  = ~m;
      end
      chk($sformatf("err_cleared_%0h", d), {7'd0, err}, 8'd0);
      for (int k = 1; k <= 9; k++) begin
         e = exp_q.pop_front();
         chk($sformatf("jk_%0h_c%0d", d, k), {6'd0, J, K}, {6'd0, e});
         chk($sformatf("busy_%0h_c%0d", d, k), {7'd0, busy}, 8'd1);
         chk($sformatf("ready_%0h_c%0d", d, k), {7'd0, in_ready}, 8'd0);
         chk($sformatf("done_%0h_c%0d", d, k), {7'd0, done}, 8'd0);
         @(negedge clk);
      end
      chk($sformatf("done_%0h_c10", d), {7'd0, done}, 8'd1);
      chk($sformatf("err_%0h_c10", d), {7'd0, err}, {7'd0, exp_err});
      chk($sformatf("busy_%0h_c10", d), {7'd0, busy}, 8'd0);
      chk($sformatf("ready_%0h_c10", d), {7'd0, in_ready}, 8'd1);
      chk($sformatf("jk_%0h_c10", d), {6'd0, J, K}, 8'd0);
   endtask

   initial begin
      #2;
      chk("rst_ready", {7'd0, in_ready}, 8'd1);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_jk", {6'd0, J, K}, 8'd0);
      chk("rst_done", {7'd0, done}, 8'd0);
      chk("rst_err", {7'd0, err}, 8'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      frame(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      frame(8'hF0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

      stuck = 1'b1;
      frame(8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      stuck = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("err_hold_%0d", i), {7'd0, err}, 8'd1);
         chk($sformatf("done_low_%0d", i), {7'd0, done}, 8'd0);
      end

      frame(8'h3C, 1'b0, 1'b0, 1'b1, 8'h81, 1'b1);
      frame(8'h81, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

      stuck    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hFF;
      in_mode  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_busy", {7'd0, busy}, 8'd1);
      chk("pre_rst_err", {7'd0, err}, 8'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_jk", {6'd0, J, K}, 8'd0);
      chk("async_rst_busy", {7'd0, busy}, 8'd0);
      chk("async_rst_ready", {7'd0, in_ready}, 8'd1);
      chk("async_rst_err", {7'd0, err}, 8'd0);
      chk("async_rst_done", {7'd0, done}, 8'd0);
      stuck = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("no_done_%0d", i), {7'd0, done}, 8'd0);
         chk($sformatf("idle_busy_%0d", i), {7'd0, busy}, 8'd0);
         @(negedge clk);
      end

      frame(8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      chk("final_done_low", {7'd0, done}, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
